// File: rtl/residual_blk_tracker_pkg.sv
// Shared definitions for the residual block tracker.
// Holds the residual block type encodings, the tracker FSM state encodings
// and the per-type TotalCoeff limit used to flag malformed coeff_token results.
package residual_blk_tracker_pkg;

    // Block types as signalled by the CAVLC decoder; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        BT_LUMA_DC   = 3'd0,
        BT_LUMA_AC   = 3'd1,
        BT_LUMA_4X4  = 3'd2,
        BT_CB_DC     = 3'd3,
        BT_CR_DC     = 3'd4,
        BT_CHROMA_AC = 3'd5
    } blkType_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_TC,
        ST_RUN,
        ST_END
    } state_t;

    // Largest TotalCoeff a block of the given type may legally carry.
    // AC blocks lose one position to the separately coded DC coefficient.
    function automatic int coeffLimit(input logic [2:0] blkType,
                                      input int maxCoeff,
                                      input int chromaDcMax);
        case (blkType)
            BT_CB_DC, BT_CR_DC:       return chromaDcMax;
            BT_LUMA_AC, BT_CHROMA_AC: return maxCoeff - 1;
            default:                  return maxCoeff;
        endcase
    endfunction

    function automatic logic isIllegalType(input logic [2:0] blkType);
        return blkType > BT_CHROMA_AC;
    endfunction

endpackage

// File: rtl/residual_blk_tracker_if.sv
// Decoder-to-tracker event bus.
// master: CAVLC decoder FSM (drives events); slave: residual_blk_tracker.
//   mb_start    new macroblock pulse
//   blk_start   new residual block pulse, blk_type sampled with it
//   tc_valid    TotalCoeff valid pulse
//   coeff_done  one level/run pair consumed pulse
interface residual_blk_tracker_if #(
    parameter int TC_W = 5
);
    logic            mb_start;
    logic            blk_start;
    logic [2:0]      blk_type;
    logic            tc_valid;
    logic [TC_W-1:0] TotalCoeff;
    logic            coeff_done;

    modport master (
        output mb_start, blk_start, blk_type, tc_valid, TotalCoeff, coeff_done
    );

    modport slave (
        input mb_start, blk_start, blk_type, tc_valid, TotalCoeff, coeff_done
    );
endinterface

// File: rtl/residual_blk_tracker_coeff_counter.sv
// Remaining-coefficient counter for one residual block.
// Ports: clk, reset_n (sync, active-high), clr (highest priority), load with
// loadValue, dec (saturates at zero); count is the registered remaining value
// and isOne flags the last coefficient of the block.
module residual_coeff_counter #(
    parameter int TC_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            load,
    input  logic [TC_W-1:0] loadValue,
    input  logic            dec,
    output logic [TC_W-1:0] count,
    output logic            isOne
);

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values, independent of block order.
        if (reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && (count != '0)) begin
            count <= count - TC_W'(1);
        end
    end

    assign isOne = (count == TC_W'(1));

endmodule

// File: rtl/residual_blk_tracker.sv
// Residual block tracker: follows one CAVLC residual block from blk_start
// through coeff_token and every level/run pair, and reports its completion.
// Ports: clk, reset_n (sync, active-high), bus (decoder events, slave side),
//   i_TotalCoeff               remaining coefficients of the current block
//   end_of_one_residual_block  one-cycle pulse when a block finishes
//   end_of_NonZeroCoeff_CAVLC  same pulse, only for blocks with TotalCoeff>0
//   blk_TotalCoeff/blk_type_o  TotalCoeff and type of the last finished block
//   *_IsAllZero                per-MB DC all-zero flags
//   blk_cnt                    blocks finished since mb_start (wrapping)
//   protocol_err               sticky protocol violation flag
module residual_blk_tracker
    import residual_blk_tracker_pkg::*;
#(
    parameter int MAX_COEFF     = 16,
    parameter int CHROMA_DC_MAX = 4,
    parameter int BLK_CNT_W     = 5,
    parameter int TC_W          = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    residual_blk_tracker_if.slave bus,
    output logic [TC_W-1:0]       i_TotalCoeff,
    output logic                  end_of_one_residual_block,
    output logic                  end_of_NonZeroCoeff_CAVLC,
    output logic [TC_W-1:0]       blk_TotalCoeff,
    output logic [2:0]            blk_type_o,
    output logic                  lumaDC_IsAllZero,
    output logic                  ChromaDC_Cb_IsAllZero,
    output logic                  ChromaDC_Cr_IsAllZero,
    output logic [BLK_CNT_W-1:0]  blk_cnt,
    output logic                  protocol_err
);

    state_t          state;
    logic [2:0]      curType;   // kept raw so illegal codes still reach blk_type_o
    logic [TC_W-1:0] tcLatched;

    int              tcLimit;
    logic            tcOver;
    logic            tcEvt;
    logic            doneEvt;
    logic [TC_W-1:0] doneTc;
    logic            cntLoad;
    logic            cntDec;
    logic            cntIsOne;
    logic            errSet;

    // Event decode. A blk_start always wins: it aborts WAIT_TC/RUN and the
    // other events of that cycle belong to nothing.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch appears.
        tcLimit = coeffLimit(curType, MAX_COEFF, CHROMA_DC_MAX);
        tcOver  = int'(bus.TotalCoeff) > tcLimit;
        tcEvt   = (state == ST_WAIT_TC) && bus.tc_valid && !bus.blk_start;
        cntLoad = tcEvt && !tcOver && (bus.TotalCoeff != '0);
        cntDec  = (state == ST_RUN) && bus.coeff_done && !bus.blk_start;
        doneEvt = (tcEvt && (tcOver || (bus.TotalCoeff == '0))) || (cntDec && cntIsOne);
        doneTc  = (state == ST_RUN) ? tcLatched : bus.TotalCoeff;

        errSet = 1'b0;
        if (bus.blk_start) begin
            errSet = isIllegalType(bus.blk_type) || (state == ST_WAIT_TC) || (state == ST_RUN);
        end else begin
            case (state)
                ST_IDLE:    errSet = bus.tc_valid || bus.coeff_done;
                ST_WAIT_TC: errSet = bus.coeff_done || (bus.tc_valid && tcOver);
                ST_RUN:     errSet = bus.tc_valid;
                default:    errSet = 1'b0;
            endcase
        end
    end

    residual_coeff_counter #(.TC_W(TC_W)) u_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (bus.blk_start),
        .load      (cntLoad),
        .loadValue (bus.TotalCoeff),
        .dec       (cntDec),
        .count     (i_TotalCoeff),
        .isOne     (cntIsOne)
    );

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state                     <= ST_IDLE;
            curType                   <= '0;
            tcLatched                 <= '0;
            end_of_one_residual_block <= 1'b0;
            end_of_NonZeroCoeff_CAVLC <= 1'b0;
            blk_TotalCoeff            <= '0;
            blk_type_o                <= '0;
            lumaDC_IsAllZero          <= 1'b1;
            ChromaDC_Cb_IsAllZero     <= 1'b1;
            ChromaDC_Cr_IsAllZero     <= 1'b1;
            blk_cnt                   <= '0;
            protocol_err              <= 1'b0;
        end else begin
            if (bus.blk_start) begin
                state <= ST_WAIT_TC;
            end else if (doneEvt) begin
                state <= ST_END;
            end else if (cntLoad) begin
                state <= ST_RUN;
            end else if (state == ST_END) begin
                state <= ST_IDLE;
            end

            if (bus.blk_start) curType   <= bus.blk_type;
            if (tcEvt)         tcLatched <= bus.TotalCoeff;
            if (errSet)        protocol_err <= 1'b1;

            end_of_one_residual_block <= doneEvt;
            end_of_NonZeroCoeff_CAVLC <= doneEvt && (doneTc != '0);

            if (doneEvt) begin
                blk_TotalCoeff <= doneTc;
                blk_type_o     <= curType;
                blk_cnt        <= blk_cnt + BLK_CNT_W'(1);
                case (curType)
                    BT_LUMA_DC: lumaDC_IsAllZero      <= (doneTc == '0);
                    BT_CB_DC:   ChromaDC_Cb_IsAllZero <= (doneTc == '0);
                    BT_CR_DC:   ChromaDC_Cr_IsAllZero <= (doneTc == '0);
                    default: ;
                endcase
            end

            // Placed after the completion updates so a coincident mb_start
            // overrides them.
            if (bus.mb_start) begin
                blk_cnt               <= '0;
                lumaDC_IsAllZero      <= 1'b1;
                ChromaDC_Cb_IsAllZero <= 1'b1;
                ChromaDC_Cr_IsAllZero <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_residual_blk_tracker.sv
// Self-checking bench for residual_blk_tracker: a block-level reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized event traffic.
module tb_residual_blk_tracker;

    localparam int TC_W      = 5;
    localparam int BLK_CNT_W = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    residual_blk_tracker_if #(.TC_W(TC_W)) bus ();

    logic [TC_W-1:0]      i_TotalCoeff;
    logic                 end_of_one_residual_block;
    logic                 end_of_NonZeroCoeff_CAVLC;
    logic [TC_W-1:0]      blk_TotalCoeff;
    logic [2:0]           blk_type_o;
    logic                 lumaDC_IsAllZero;
    logic                 ChromaDC_Cb_IsAllZero;
    logic                 ChromaDC_Cr_IsAllZero;
    logic [BLK_CNT_W-1:0] blk_cnt;
    logic                 protocol_err;

    residual_blk_tracker #(
        .MAX_COEFF(16), .CHROMA_DC_MAX(4), .BLK_CNT_W(BLK_CNT_W), .TC_W(TC_W)
    ) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .bus                       (bus.slave),
        .i_TotalCoeff              (i_TotalCoeff),
        .end_of_one_residual_block (end_of_one_residual_block),
        .end_of_NonZeroCoeff_CAVLC (end_of_NonZeroCoeff_CAVLC),
        .blk_TotalCoeff            (blk_TotalCoeff),
        .blk_type_o                (blk_type_o),
        .lumaDC_IsAllZero          (lumaDC_IsAllZero),
        .ChromaDC_Cb_IsAllZero     (ChromaDC_Cb_IsAllZero),
        .ChromaDC_Cr_IsAllZero     (ChromaDC_Cr_IsAllZero),
        .blk_cnt                   (blk_cnt),
        .protocol_err              (protocol_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A block is "open" from blk_start until it ends; once its TotalCoeff is
    // known it counts down the remaining pairs.
    bit mOpen, mTcSeen, mEnd, mNz, mErr, mFin;
    int mRemain, mTcVal, mType, mBlkTc, mBlkType, mCnt, mFinTc;
    bit mFlag [3];   // luma DC, Cb DC, Cr DC
    bit cmpOn = 1'b0;

    function automatic int limitOf(input int t);
        if (t == 3 || t == 4) return 4;
        if (t == 1 || t == 5) return 15;
        return 16;
    endfunction

    always @(posedge clk) begin
        if (reset_n) begin
            mOpen = 0; mTcSeen = 0; mEnd = 0; mNz = 0; mErr = 0;
            mRemain = 0; mTcVal = 0; mType = 0; mBlkTc = 0; mBlkType = 0; mCnt = 0;
            for (int k = 0; k < 3; k++) mFlag[k] = 1;
        end else begin
            mFin = 0;
            mFinTc = 0;
            if (bus.blk_start) begin
                if (mOpen) mErr = 1;
                if (bus.blk_type > 3'd5) mErr = 1;
                mOpen = 1; mTcSeen = 0; mRemain = 0; mType = int'(bus.blk_type);
            end else if (mOpen && !mTcSeen) begin
                if (bus.coeff_done) mErr = 1;
                if (bus.tc_valid) begin
                    if (int'(bus.TotalCoeff) > limitOf(mType)) begin
                        mErr = 1; mFin = 1; mFinTc = int'(bus.TotalCoeff);
                    end else if (bus.TotalCoeff == 0) begin
                        mFin = 1; mFinTc = 0;
                    end else begin
                        mTcSeen = 1; mRemain = int'(bus.TotalCoeff); mTcVal = mRemain;
                    end
                end
            end else if (mOpen) begin
                if (bus.tc_valid) mErr = 1;
                if (bus.coeff_done) begin
                    mRemain--;
                    if (mRemain == 0) begin mFin = 1; mFinTc = mTcVal; end
                end
            end else if (!mEnd && (bus.tc_valid || bus.coeff_done)) begin
                mErr = 1;   // stray events outside a block (the end cycle tolerates them)
            end
            mEnd = mFin;
            mNz = mFin && (mFinTc != 0);
            if (mFin) begin
                mOpen = 0;
                mBlkTc = mFinTc;
                mBlkType = mType;
                mCnt = (mCnt + 1) % (1 << BLK_CNT_W);
                if (mType == 0) mFlag[0] = (mFinTc == 0);
                if (mType == 3) mFlag[1] = (mFinTc == 0);
                if (mType == 4) mFlag[2] = (mFinTc == 0);
            end
            if (bus.mb_start) begin
                mCnt = 0;
                for (int k = 0; k < 3; k++) mFlag[k] = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmpOn) begin
            check("m_i_TotalCoeff", int'(i_TotalCoeff), mRemain);
            check("m_end_blk", int'(end_of_one_residual_block), int'(mEnd));
            check("m_end_nz", int'(end_of_NonZeroCoeff_CAVLC), int'(mNz));
            check("m_blk_TotalCoeff", int'(blk_TotalCoeff), mBlkTc);
            check("m_blk_type_o", int'(blk_type_o), mBlkType);
            check("m_lumaDC", int'(lumaDC_IsAllZero), int'(mFlag[0]));
            check("m_CbDC", int'(ChromaDC_Cb_IsAllZero), int'(mFlag[1]));
            check("m_CrDC", int'(ChromaDC_Cr_IsAllZero), int'(mFlag[2]));
            check("m_blk_cnt", int'(blk_cnt), mCnt);
            check("m_protocol_err", int'(protocol_err), int'(mErr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clearInputs();
        bus.mb_start = 0; bus.blk_start = 0; bus.blk_type = '0;
        bus.tc_valid = 0; bus.TotalCoeff = '0; bus.coeff_done = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of events; outputs are checkable when this returns.
    task automatic ev(input bit mb, input bit bs, input int bt,
                      input bit tv, input int tc, input bit cd);
        bus.mb_start = mb; bus.blk_start = bs; bus.blk_type = 3'(bt);
        bus.tc_valid = tv; bus.TotalCoeff = 5'(tc); bus.coeff_done = cd;
        tick();
        clearInputs();
    endtask

    task automatic doReset();
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
    endtask

    initial begin
        clearInputs();
        doReset();
        cmpOn = 1'b1;
        check("rst_i", int'(i_TotalCoeff), 0);
        check("rst_flags", int'({lumaDC_IsAllZero, ChromaDC_Cb_IsAllZero, ChromaDC_Cr_IsAllZero}), 7);
        check("rst_cnt", int'(blk_cnt), 0);
        check("rst_err", int'(protocol_err), 0);

        // LUMA_4x4, three pairs spaced two cycles apart
        ev(1,0,0,0,0,0);
        ev(0,1,2,0,0,0);
        ev(0,0,0,1,3,0);  check("l4_i3", int'(i_TotalCoeff), 3);
        tick();
        ev(0,0,0,0,0,1);  check("l4_i2", int'(i_TotalCoeff), 2);
        tick();
        ev(0,0,0,0,0,1);  check("l4_i1", int'(i_TotalCoeff), 1);
        check("l4_noend", int'(end_of_one_residual_block), 0);
        tick();
        ev(0,0,0,0,0,1);
        check("l4_i0", int'(i_TotalCoeff), 0);
        check("l4_end", int'(end_of_one_residual_block), 1);
        check("l4_nz", int'(end_of_NonZeroCoeff_CAVLC), 1);
        check("l4_tc", int'(blk_TotalCoeff), 3);
        check("l4_cnt", int'(blk_cnt), 1);
        tick();
        check("l4_endlow", int'(end_of_one_residual_block), 0);

        // DC flags
        ev(1,0,0,0,0,0);  check("mb_cnt0", int'(blk_cnt), 0);
        ev(0,1,0,0,0,0);
        ev(0,0,0,1,0,0);
        check("ldc_end", int'(end_of_one_residual_block), 1);
        check("ldc_nz", int'(end_of_NonZeroCoeff_CAVLC), 0);
        check("ldc_flag", int'(lumaDC_IsAllZero), 1);
        ev(0,1,3,0,0,0);
        ev(0,0,0,1,2,0);
        ev(0,0,0,0,0,1);
        ev(0,0,0,0,0,1);
        check("cb_end", int'(end_of_one_residual_block), 1);
        check("cb_flag", int'(ChromaDC_Cb_IsAllZero), 0);
        check("cr_flag", int'(ChromaDC_Cr_IsAllZero), 1);
        check("cb_cnt", int'(blk_cnt), 2);
        check("cb_err", int'(protocol_err), 0);

        // Limits: CB_DC 4 legal, 5 overflows; LUMA_AC 15 legal, 16 overflows
        ev(0,1,3,0,0,0);
        ev(0,0,0,1,4,0);  check("cb4_i", int'(i_TotalCoeff), 4);
        check("cb4_err", int'(protocol_err), 0);
        for (int k = 0; k < 4; k++) ev(0,0,0,0,0,1);
        check("cb4_end", int'(end_of_one_residual_block), 1);
        ev(0,1,3,0,0,0);
        ev(0,0,0,1,5,0);
        check("cb5_err", int'(protocol_err), 1);
        check("cb5_end", int'(end_of_one_residual_block), 1);
        check("cb5_tc", int'(blk_TotalCoeff), 5);
        check("cb5_i", int'(i_TotalCoeff), 0);
        doReset();
        ev(0,1,1,0,0,0);
        ev(0,0,0,1,15,0); check("lac15_i", int'(i_TotalCoeff), 15);
        check("lac15_err", int'(protocol_err), 0);
        doReset();
        ev(0,1,1,0,0,0);
        ev(0,0,0,1,16,0);
        check("lac16_err", int'(protocol_err), 1);
        check("lac16_end", int'(end_of_one_residual_block), 1);
        check("lac16_tc", int'(blk_TotalCoeff), 16);

        // Abort in RUN
        doReset();
        ev(0,1,2,0,0,0);
        ev(0,0,0,1,4,0);
        ev(0,0,0,0,0,1);
        ev(0,0,0,0,0,1);  check("ab_i2", int'(i_TotalCoeff), 2);
        ev(0,1,1,0,0,0);
        check("ab_noend", int'(end_of_one_residual_block), 0);
        check("ab_err", int'(protocol_err), 1);
        ev(0,0,0,1,1,0);
        ev(0,0,0,0,0,1);
        check("ab_end", int'(end_of_one_residual_block), 1);
        check("ab_type", int'(blk_type_o), 1);
        check("ab_cnt", int'(blk_cnt), 1);

        // tc_valid with coeff_done in WAIT_TC; illegal type
        doReset();
        ev(0,1,2,0,0,0);
        ev(0,0,0,1,2,1);
        check("tccd_i", int'(i_TotalCoeff), 2);
        check("tccd_err", int'(protocol_err), 1);
        doReset();
        ev(0,1,6,0,0,0);  check("ill_err", int'(protocol_err), 1);

        // Reset in RUN
        doReset();
        ev(0,1,4,0,0,0);
        ev(0,0,0,1,1,0);
        ev(0,0,0,0,0,1);  check("cr_flag0", int'(ChromaDC_Cr_IsAllZero), 0);
        ev(0,1,2,0,0,0);
        ev(0,0,0,1,7,0);  check("run7_i", int'(i_TotalCoeff), 7);
        doReset();
        check("rr_i", int'(i_TotalCoeff), 0);
        check("rr_cr", int'(ChromaDC_Cr_IsAllZero), 1);
        check("rr_cnt", int'(blk_cnt), 0);

        // mb_start coincident with the completing event
        ev(0,1,0,0,0,0);
        ev(0,0,0,1,1,0);
        ev(1,0,0,0,0,1);
        check("mbe_end", int'(end_of_one_residual_block), 1);
        check("mbe_cnt", int'(blk_cnt), 0);
        check("mbe_flag", int'(lumaDC_IsAllZero), 1);
        ev(0,1,2,0,0,0);
        ev(1,0,0,1,0,0);
        check("mbz_end", int'(end_of_one_residual_block), 1);
        check("mbz_cnt", int'(blk_cnt), 0);

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                ev($urandom_range(0, 4) == 0, 1, int'($urandom_range(0, 7)), 0, 0, 0);
            end else if (r < 30) begin
                ev(0, 0, 0, 1, int'($urandom_range(0, 17)), $urandom_range(0, 9) == 0);
            end else if (r < 65) begin
                ev(0, 0, 0, 0, 0, 1);
            end else if (r < 68) begin
                ev(1, 0, 0, 0, 0, 0);
            end else if (r < 69) begin
                doReset();
            end else begin
                tick();
            end
        end

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
